// File: rtl/mp_alu_pkg.sv
// rtl/mp_alu_pkg.sv - operation codes and FSM states shared by the multi-precision add/sub unit
package mp_alu_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_ADDC = 2'b01,
        OP_SUB  = 2'b10,
        OP_SUBC = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic logic is_sub(input op_e o);
        return (o == OP_SUB) || (o == OP_SUBC);
    endfunction

endpackage

// File: rtl/mp_addc_slice.sv
// rtl/mp_addc_slice.sv - one-word adder with optional B inversion, carry in/out and zero detect
// Ports: a, b     operand words
//        inv_b    invert b (subtraction as a + ~b + 1)
//        cin      carry into bit 0
//        sum      WIDTH-bit result word
//        cout     carry out of the top bit
//        zero     sum == 0
module mp_addc_slice
    import mp_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             inv_b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             zero
);

    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   full;

    always_comb begin
        b_eff = inv_b ? ~b : b;
        full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
        sum   = full[WIDTH-1:0];
        cout  = full[WIDTH];
        zero  = (full[WIDTH-1:0] == '0);
    end

endmodule

// File: rtl/mp_addc_unit.sv
// rtl/mp_addc_unit.sv - multi-cycle multi-precision ADD/ADDC/SUB/SUBC unit, one word per clock
// Ports: clock, reset (async active-low), enable (global stall)
//        start/op          request and operation, taken only in IDLE
//        ld_we/ld_sel/ld_addr/ld_data  operand buffer write (A when ld_sel=0, B when 1)
//        rd_addr/rd_data   combinational read of the result buffer
//        busy/done         RUN level / single DONE cycle
//        cf/zf/nf          whole-operand flags, updated when the last word is written
module mp_addc_unit
    import mp_alu_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int WORDS = 4,
    parameter int AW    = $clog2(WORDS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic             ld_we,
    input  logic             ld_sel,
    input  logic [AW-1:0]    ld_addr,
    input  logic [WIDTH-1:0] ld_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data,
    output logic             busy,
    output logic             done,
    output logic             cf,
    output logic             zf,
    output logic             nf
);

    state_e           state, state_nxt;
    logic [AW-1:0]    idx;
    logic             c;
    logic             zacc;
    op_e              op_q;
    logic [WIDTH-1:0] buf_a [WORDS];
    logic [WIDTH-1:0] buf_b [WORDS];
    logic [WIDTH-1:0] buf_r [WORDS];

    logic             start_ok, step, ld_ok, last, seed;
    logic [WIDTH-1:0] sum;
    logic             cout, zero;

    assign last    = (idx == AW'(WORDS - 1));
    assign busy    = (state == RUN);
    assign done    = (state == DONE);
    assign rd_data = buf_r[rd_addr];

    // Carry seed: subtraction is a + ~b + 1, so a borrow-in removes that +1.
    always_comb begin
        case (op_e'(op))
            OP_ADD:  seed = 1'b0;
            OP_ADDC: seed = cf;
            OP_SUB:  seed = 1'b1;
            OP_SUBC: seed = ~cf;
            default: seed = 1'b0;
        endcase
    end

    mp_addc_slice #(.WIDTH(WIDTH)) u_slice (
        .a     (buf_a[idx]),
        .b     (buf_b[idx]),
        .inv_b (is_sub(op_q)),
        .cin   (c),
        .sum   (sum),
        .cout  (cout),
        .zero  (zero)
    );

    always_comb begin
        state_nxt = state;
        start_ok  = 1'b0;
        step      = 1'b0;
        ld_ok     = 1'b0;
        case (state)
            IDLE: begin
                ld_ok = ld_we;
                if (start) begin
                    start_ok  = 1'b1;
                    state_nxt = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) state_nxt = DONE;
            end
            DONE: begin
                ld_ok     = ld_we;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            idx   <= '0;
            c     <= 1'b0;
            zacc  <= 1'b1;
            op_q  <= OP_ADD;
            cf    <= 1'b0;
            zf    <= 1'b0;
            nf    <= 1'b0;
            for (int i = 0; i < WORDS; i++) begin
                buf_a[i] <= '0;
                buf_b[i] <= '0;
                buf_r[i] <= '0;
            end
        end else if (enable) begin
            state <= state_nxt;
            if (start_ok) begin
                idx  <= '0;
                op_q <= op_e'(op);
                c    <= seed;
                zacc <= 1'b1;
            end
            if (step) begin
                buf_r[idx] <= sum;
                c          <= cout;
                zacc       <= zacc & zero;
                idx        <= last ? '0 : idx + AW'(1);
                if (last) begin
                    // Sub ops report borrow, the inverse of the adder carry.
                    cf <= is_sub(op_q) ? ~cout : cout;
                    zf <= zacc & zero;
                    nf <= sum[WIDTH-1];
                end
            end
            if (ld_ok) begin
                if (ld_sel) buf_b[ld_addr] <= ld_data;
                else        buf_a[ld_addr] <= ld_data;
            end
        end
    end

endmodule

// File: tb/tb_mp_addc_unit.sv
// tb/tb_mp_addc_unit.sv - scoreboard bench for mp_addc_unit with a whole-operand arithmetic model
module tb_mp_addc_unit;

    localparam int WIDTH = 16;
    localparam int WORDS = 4;
    localparam int AW    = 2;
    localparam int N     = WIDTH * WORDS;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b1;
    logic             start = 1'b0;
    logic [1:0]       op = 2'b00;
    logic             ld_we = 1'b0;
    logic             ld_sel = 1'b0;
    logic [AW-1:0]    ld_addr = '0;
    logic [WIDTH-1:0] ld_data = '0;
    logic [AW-1:0]    rd_addr = '0;
    logic [WIDTH-1:0] rd_data;
    logic             busy, done, cf, zf, nf;

    mp_addc_unit #(.WIDTH(WIDTH), .WORDS(WORDS)) dut (
        .clock   (clock),
        .reset   (reset),
        .enable  (enable),
        .start   (start),
        .op      (op),
        .ld_we   (ld_we),
        .ld_sel  (ld_sel),
        .ld_addr (ld_addr),
        .ld_data (ld_data),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .busy    (busy),
        .done    (done),
        .cf      (cf),
        .zf      (zf),
        .nf      (nf)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0] res;
        logic         cf;
        logic         zf;
        logic         nf;
    } exp_t;

    exp_t         sb[$];
    int           tests = 0;
    int           fails = 0;
    logic [N-1:0] a_m = '0;
    logic [N-1:0] b_m = '0;
    logic         cf_m = 1'b0;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Whole-operand reference: treat A and B as N-bit integers.
    task automatic model(input logic [1:0] o);
        logic [N:0] s;
        exp_t       e;
        case (o)
            2'b00:   s = {1'b0, a_m} + {1'b0, b_m};
            2'b01:   s = {1'b0, a_m} + {1'b0, b_m} + {{N{1'b0}}, cf_m};
            2'b10:   s = {1'b0, a_m} - {1'b0, b_m};
            default: s = {1'b0, a_m} - {1'b0, b_m} - {{N{1'b0}}, cf_m};
        endcase
        // For subtraction a negative result wraps, so bit N is the borrow.
        e.res = s[N-1:0];
        e.cf  = s[N];
        e.zf  = (s[N-1:0] == '0);
        e.nf  = s[N-1];
        cf_m  = e.cf;
        sb.push_back(e);
    endtask

    // Monitor: whenever the unit presents done, read back the result and compare.
    initial begin
        logic [N-1:0] r;
        exp_t         e;
        forever begin
            @(negedge clock);
            if (done) begin
                for (int i = 0; i < WORDS; i++) begin
                    rd_addr = AW'(i);
                    #1;
                    r[i*WIDTH +: WIDTH] = rd_data;
                end
                if (sb.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_done: got done=1 expected no pending operation");
                end else begin
                    e = sb.pop_front();
                    check("result", r, e.res);
                    check("cf", {{(N-1){1'b0}}, cf}, {{(N-1){1'b0}}, e.cf});
                    check("zf", {{(N-1){1'b0}}, zf}, {{(N-1){1'b0}}, e.zf});
                    check("nf", {{(N-1){1'b0}}, nf}, {{(N-1){1'b0}}, e.nf});
                end
            end
        end
    end

    task automatic load(input logic [N-1:0] a, input logic [N-1:0] b);
        for (int s = 0; s < 2; s++) begin
            for (int i = 0; i < WORDS; i++) begin
                ld_we   = 1'b1;
                ld_sel  = (s == 1);
                ld_addr = AW'(i);
                ld_data = (s == 0) ? a[i*WIDTH +: WIDTH] : b[i*WIDTH +: WIDTH];
                @(negedge clock);
            end
        end
        ld_we = 1'b0;
        a_m   = a;
        b_m   = b;
    endtask

    // mode 0: plain run; 1: two stalled edges plus start/ld_we pokes in RUN; 2: reset in 2nd RUN cycle
    task automatic run_op(input logic [1:0] o, input int mode, output int lat, output int busy_n);
        bit seen;
        seen   = 1'b0;
        lat    = 0;
        busy_n = 0;
        op     = o;
        start  = 1'b1;
        model(o);
        for (int k = 0; k < 50; k++) begin
            @(negedge clock);
            start = 1'b0;
            lat++;
            if (busy) busy_n++;
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (mode == 1) begin
                ld_we = 1'b0;
                if (lat == 2 || lat == 3) enable = 1'b0;
                if (lat == 4) begin
                    enable = 1'b1; start = 1'b1;
                    ld_we = 1'b1; ld_sel = 1'b0; ld_addr = '0; ld_data = 16'hDEAD;
                end
                if (lat == 5) begin
                    start = 1'b1;
                    ld_we = 1'b1; ld_sel = 1'b1; ld_addr = AW'(1); ld_data = 16'hBEEF;
                end
            end
            if (mode == 2 && lat == 2) begin
                reset = 1'b0;
                #1;
                check("rst_busy", {{(N-1){1'b0}}, busy}, '0);
                check("rst_done", {{(N-1){1'b0}}, done}, '0);
                check("rst_flags", {{(N-3){1'b0}}, cf, zf, nf}, '0);
                for (int i = 0; i < WORDS; i++) begin
                    rd_addr = AW'(i);
                    #1;
                    check("rst_rd_data", {{(N-WIDTH){1'b0}}, rd_data}, '0);
                end
                sb.delete();
                a_m  = '0;
                b_m  = '0;
                cf_m = 1'b0;
                @(negedge clock);
                reset = 1'b1;
                seen  = 1'b1;
                break;
            end
        end
        enable = 1'b1;
        start  = 1'b0;
        ld_we  = 1'b0;
        if (!seen) begin
            tests++;
            fails++;
            $display("FAIL done_timeout: got no done expected done within 50 cycles");
        end
        @(negedge clock);
    endtask

    function automatic logic [N-1:0] rand_operand();
        logic [N-1:0] v;
        for (int i = 0; i < WORDS; i++) begin
            case ($urandom_range(0, 3))
                0:       v[i*WIDTH +: WIDTH] = '0;
                1:       v[i*WIDTH +: WIDTH] = '1;
                default: v[i*WIDTH +: WIDTH] = WIDTH'($urandom);
            endcase
        end
        return v;
    endfunction

    initial begin
        int lat, bn;
        logic [N-1:0] t1_a, t1_b;
        t1_a = 64'h0001_0000_FFFF_F000;
        t1_b = 64'h0000_0000_0000_1000;

        #2;
        check("reset_busy", {{(N-1){1'b0}}, busy}, '0);
        check("reset_done", {{(N-1){1'b0}}, done}, '0);
        check("reset_flags", {{(N-3){1'b0}}, cf, zf, nf}, '0);
        for (int i = 0; i < WORDS; i++) begin
            rd_addr = AW'(i);
            #1;
            check("reset_rd_data", {{(N-WIDTH){1'b0}}, rd_data}, '0);
        end
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);

        load(t1_a, t1_b);
        run_op(2'b00, 0, lat, bn);
        check("add_latency", N'(lat), N'(5));
        check("add_busy_cycles", N'(bn), N'(4));

        load('1, 64'h1);
        run_op(2'b00, 0, lat, bn);
        load('0, '0);
        run_op(2'b01, 0, lat, bn);

        load('0, 64'h1);
        run_op(2'b10, 0, lat, bn);
        load('0, '0);
        run_op(2'b11, 0, lat, bn);

        load(t1_a, t1_b);
        run_op(2'b00, 1, lat, bn);
        check("stall_latency", N'(lat), N'(7));
        check("stall_busy_cycles", N'(bn), N'(6));
        run_op(2'b00, 0, lat, bn);

        load('0, 64'h1);
        run_op(2'b10, 0, lat, bn);
        run_op(2'b10, 2, lat, bn);
        load(t1_a, t1_b);
        run_op(2'b01, 0, lat, bn);
        check("post_reset_latency", N'(lat), N'(5));

        for (int n = 0; n < 30; n++) begin
            if ($urandom_range(0, 3) != 0) load(rand_operand(), rand_operand());
            run_op(2'($urandom_range(0, 3)), 0, lat, bn);
        end

        repeat (3) @(negedge clock);
        if (sb.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL pending_results: got %0d left expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mp_addc_unit.md
# mp_addc_unit

Parametrised multi-precision add/subtract execution unit, the successor to the CPU's single-word ADD/ADDC datapath. It holds two WORDS×WIDTH operand buffers and iterates over them least-significant word first, propagating carry or borrow between words, one word per clock. It produces a WORDS×WIDTH result and whole-operand flags cf/zf/nf. It sits beside the CPU execute stage as a multi-cycle functional unit with a start/busy/done handshake and the CPU's global `enable` stall.

## Interface
Parameters:
- `WIDTH`, 16, bits per word (≥2)
- `WORDS`, 4, words per operand (≥2)
- `AW`, `$clog2(WORDS)`, word index width (derived; do not override)

Ports:
- `clock`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `enable`  in  1  global stall; low freezes every register, including FSM, buffers and flags
- `start`  in  1  one-cycle request; sampled only in IDLE with `enable`=1
- `op`  in  2  00 ADD, 01 ADDC, 10 SUB, 11 SUBC; sampled with `start`
- `ld_we`  in  1  operand buffer write strobe
- `ld_sel`  in  1  0 writes buffer A, 1 writes buffer B
- `ld_addr`  in  AW  word index
- `ld_data`  in  WIDTH  word to write
- `rd_addr`  in  AW  result word index
- `rd_data`  out  WIDTH  result word, combinational read of the result buffer
- `busy`  out  1  high in RUN
- `done`  out  1  high for the single DONE cycle
- `cf`, `zf`, `nf`  out  1 each  flag register

## Operation
- FSM states:
  - IDLE: `start`&`enable` goes to RUN; `idx`←0; `op` is latched; carry `c` is seeded.
  - RUN: one word per cycle; after word WORDS-1, goes to DONE.
  - DONE: goes to IDLE on the next enabled edge.
- Carry seed: ADD c=0; ADDC c=`cf`; SUB c=1; SUBC c=~`cf`.
- Per RUN cycle, with B' = B[idx] for ADD/ADDC and ~B[idx] for SUB/SUBC: {c, res[idx]} ← A[idx] + B' + c, computed at WIDTH+1 bits. `zacc` ← `zacc` & (sum word == 0). `idx` increments.
- Flags are written on the edge that writes word WORDS-1:
  - add ops: `cf` = final carry; sub ops: `cf` = ~final carry, i.e. borrow.
  - `zf` = all result words zero.
  - `nf` = res[WORDS-1][WIDTH-1].
  - Flags are otherwise unchanged.
- `ld_we` is accepted only in IDLE and DONE; it is dropped in RUN.
- `start` in RUN or DONE is ignored and is not queued.
- Reading `rd_addr` during RUN returns the current buffer contents, which may be partially updated.
- Reset, including mid-operation: state IDLE, `idx`=0, `c`=0, all A/B/result words 0, `cf`=`zf`=`nf`=0, `busy`=0, `done`=0, `rd_data`=0.

## Timing
- Start is accepted at edge E0. Words 0..WORDS-1 are written at edges E1..E_WORDS. Flags are valid after E_WORDS. `done` is high from E_WORDS to E_WORDS+1. A new `start` is accepted at E_WORDS+2 at the earliest.
- Total latency: start to `done` is WORDS+1 cycles; throughput is one op per WORDS+2 cycles.
- `enable`=0 adds exactly one cycle per low cycle to every later event. During the stall `done` and `busy` hold their levels.
- `ld_we` in DONE and a new `start` can never collide, because `start` is ignored in DONE.

## Structure
- Package `mp_alu_pkg`: `op` encodings (OP_ADD, OP_ADDC, OP_SUB, OP_SUBC) and the FSM state constants (IDLE, RUN, DONE).
- Sub-module `mp_addc_slice`: combinational WIDTH-bit adder with B-invert, carry-in, carry-out and zero-detect, instantiated once and shared across iterations.
- Top level holds the FSM, `idx` counter, carry and zero accumulators, the three word buffers and the flag register.

## Test plan
(WIDTH=16, WORDS=4; operands written as w3_w2_w1_w0)
- ADD A=0001_0000_FFFF_F000, B=0000_0000_0000_1000 -> result 0001_0001_0000_0000, cf=0, zf=0, nf=0; `done` exactly 5 cycles after start, `busy` high for 4 cycles.
- ADD A=FFFF_FFFF_FFFF_FFFF, B=0000_0000_0000_0001 -> result 0, cf=1, zf=1. Then ADDC with A=0, B=0 -> result 0000_0000_0000_0001, cf=0, zf=0.
- SUB A=0, B=0000_0000_0000_0001 -> result all FFFF, cf=1, nf=1, zf=0. Then SUBC with A=0, B=0 -> result all FFFF, cf=1, nf=1.
- Drop `enable` for 2 cycles during RUN; pulse `start` and `ld_we` during RUN -> `done` 7 cycles after the original start; result identical to the unstalled case; A/B buffers unchanged.
- Assert `reset` in the 2nd RUN cycle -> immediately busy=0, done=0, cf/zf/nf=0, `rd_data`=0 for every address; the next start runs normally.
